// File: rtl/cmd_phy_sequencer_pkg.sv
// Shared types and constants for the CMD-line PHY sequencer: one-hot FSM
// state encoding, response-type codes and the short-response width.
package cmd_phy_pkg;

    typedef enum logic [6:0] {
        ST_IDLE      = 7'b0000001,
        ST_LOAD      = 7'b0000010,
        ST_SEND      = 7'b0000100,
        ST_WAIT_RESP = 7'b0001000,
        ST_DELIVER   = 7'b0010000,
        ST_WAIT_ACK  = 7'b0100000,
        ST_ACK       = 7'b1000000
    } cmd_phy_state_t;

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_SHORT = 2'd1;
    localparam logic [1:0] RESP_LONG  = 2'd2;

    localparam int SHORT_RESP_W = 48;

endpackage

// File: rtl/cmd_phy_sequencer_timer.sv
// N_CR response timer: counts enabled cycles and pulses expire on the
// TIMEOUT_CYCLES-th one, then restarts from zero.
module cmd_resp_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic sd_clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // clear dominates so an abort in the terminal cycle never reports expiry
    assign expire = enable && !clear && (count == LAST);

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cmd_phy_sequencer.sv
// CMD-line PHY sequencer: load/transmit a command, wait for the response with
// timeout and retry, deliver it upstream and finish with a strobe/ack handshake.
module cmd_phy_sequencer
    import cmd_phy_pkg::*;
#(
    parameter int RESP_W         = 136,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 2,
    localparam int RC_W          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              strobe_in,
    input  logic [1:0]        resp_type,
    input  logic              ack_in,
    input  logic              idle_in,
    input  logic              transmission_complete,
    input  logic              reception_complete,
    input  logic [RESP_W-1:0] pad_response,
    output logic              strobe_out,
    output logic [RESP_W-1:0] response,
    output logic              command_timeout,
    output logic [RC_W-1:0]   retry_count,
    output logic              ack_out,
    output logic              load_send,
    output logic              enable_pts_wrapper,
    output logic              enable_stp_wrapper,
    output logic              reset_wrapper,
    output logic              pad_state,
    output logic              pad_enable,
    output logic [6:0]        state_debug
);

    cmd_phy_state_t    state, state_next;
    logic [1:0]        resp_type_q;
    logic              accept;
    logic              retry_inc;
    logic              capture_en;
    logic              capture_timeout;
    logic [RESP_W-1:0] capture_resp;
    logic [RESP_W-1:0] shaped_resp;
    logic              timer_clear;
    logic              timer_enable;
    logic              expire;

    assign timer_enable = (state == ST_WAIT_RESP);
    assign timer_clear  = !timer_enable || idle_in;

    cmd_resp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .expire   (expire)
    );

    // Short responses keep only the low 48 bits; long (and code 3) keep all.
    always_comb begin
        shaped_resp = pad_response;
        if (resp_type_q == RESP_SHORT) begin
            for (int i = SHORT_RESP_W; i < RESP_W; i++) begin
                shaped_resp[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        retry_inc       = 1'b0;
        capture_en      = 1'b0;
        capture_timeout = 1'b0;
        capture_resp    = '0;
        unique case (state)
            ST_IDLE: begin
                if (strobe_in) begin
                    state_next = ST_LOAD;
                    accept     = 1'b1;
                end
            end
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: begin
                if (transmission_complete) begin
                    if (resp_type_q == RESP_NONE) begin
                        state_next = ST_DELIVER;
                        capture_en = 1'b1;
                    end else begin
                        state_next = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                // reception in the terminal timer cycle beats the timeout
                if (reception_complete) begin
                    state_next   = ST_DELIVER;
                    capture_en   = 1'b1;
                    capture_resp = shaped_resp;
                end else if (expire) begin
                    if (retry_count < RC_W'(MAX_RETRY)) begin
                        state_next = ST_LOAD;
                        retry_inc  = 1'b1;
                    end else begin
                        state_next      = ST_DELIVER;
                        capture_en      = 1'b1;
                        capture_timeout = 1'b1;
                    end
                end
            end
            ST_DELIVER:  state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack_in) state_next = ST_ACK;
            ST_ACK:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        if (idle_in && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            retry_inc  = 1'b0;
            capture_en = 1'b0;
        end
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            resp_type_q     <= RESP_NONE;
            retry_count     <= '0;
            response        <= '0;
            command_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                resp_type_q <= resp_type;
                retry_count <= '0;
            end else if (retry_inc) begin
                retry_count <= retry_count + RC_W'(1);
            end
            if (capture_en) begin
                response        <= capture_resp;
                command_timeout <= capture_timeout;
            end
        end
    end

    assign reset_wrapper      = (state == ST_IDLE);
    assign enable_pts_wrapper = (state == ST_LOAD) || (state == ST_SEND);
    assign pad_state          = enable_pts_wrapper;
    assign pad_enable         = enable_pts_wrapper;
    assign load_send          = (state == ST_SEND);
    assign enable_stp_wrapper = (state == ST_WAIT_RESP);
    assign strobe_out         = (state == ST_DELIVER);
    assign ack_out            = (state == ST_ACK);
    assign state_debug        = state;

endmodule

// File: tb/tb_cmd_phy_sequencer.sv
// Bench for cmd_phy_sequencer: table of command transactions plus hand-written
// abort, timeout/retry, race and mid-transaction reset sequences.
module tb_cmd_phy_sequencer;
    import cmd_phy_pkg::*;

    localparam int RESP_W         = 136;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAX_RETRY      = 2;
    localparam int RC_W           = 2;
    localparam int EW             = RESP_W + 1 + RC_W;

    logic              sd_clock = 1'b0;
    logic              reset = 1'b0;
    logic              strobe_in = 1'b0;
    logic [1:0]        resp_type = 2'd0;
    logic              ack_in = 1'b0;
    logic              idle_in = 1'b0;
    logic              transmission_complete = 1'b0;
    logic              reception_complete = 1'b0;
    logic [RESP_W-1:0] pad_response = '0;
    logic              strobe_out;
    logic [RESP_W-1:0] response;
    logic              command_timeout;
    logic [RC_W-1:0]   retry_count;
    logic              ack_out;
    logic              load_send;
    logic              enable_pts_wrapper;
    logic              enable_stp_wrapper;
    logic              reset_wrapper;
    logic              pad_state;
    logic              pad_enable;
    logic [6:0]        state_debug;

    cmd_phy_sequencer #(
        .RESP_W(RESP_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in),
        .resp_type(resp_type), .ack_in(ack_in), .idle_in(idle_in),
        .transmission_complete(transmission_complete),
        .reception_complete(reception_complete), .pad_response(pad_response),
        .strobe_out(strobe_out), .response(response),
        .command_timeout(command_timeout), .retry_count(retry_count),
        .ack_out(ack_out), .load_send(load_send),
        .enable_pts_wrapper(enable_pts_wrapper),
        .enable_stp_wrapper(enable_stp_wrapper), .reset_wrapper(reset_wrapper),
        .pad_state(pad_state), .pad_enable(pad_enable), .state_debug(state_debug)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct {
        logic [1:0]        rt;
        int                tc_delay;
        int                rc_delay;
        logic [RESP_W-1:0] pad;
        logic [RESP_W-1:0] exp_resp;
    } vec_t;

    vec_t              vecs[6];
    logic [EW-1:0]     exp_q[$];
    int                n_tests = 0;
    int                n_fail = 0;
    logic [RESP_W-1:0] last_resp = '0;
    logic              prev_strobe = 1'b0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe_out pulse must match the oldest expected result.
    always @(negedge sd_clock) begin
        if (reset && strobe_out) begin
            check("strobe_width", {{(EW-1){1'b0}}, prev_strobe}, '0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got response %h with no pending command", response);
            end else begin
                check("delivered", {response, command_timeout, retry_count}, exp_q.pop_front());
            end
        end
        prev_strobe = strobe_out;
    end

    function automatic logic [8:0] ctl_vec();
        return {strobe_out, command_timeout, ack_out, load_send, enable_pts_wrapper,
                enable_stp_wrapper, reset_wrapper, pad_state, pad_enable};
    endfunction

    task automatic wait_strobe();
        int n = 0;
        while (!strobe_out && n < 300) begin
            @(negedge sd_clock);
            n++;
        end
        check("strobe_seen", {{(EW-1){1'b0}}, strobe_out}, 1);
    endtask

    task automatic do_ack();
        @(negedge sd_clock);
        check("wait_ack_idle", {strobe_out, ack_out, reset_wrapper}, 3'b000);
        @(negedge sd_clock);
        check("ack_in_ignored_wait", {ack_out, reset_wrapper}, 2'b00);
        ack_in = 1'b1;
        @(negedge sd_clock);
        ack_in = 1'b0;
        check("ack_out_pulse", {ack_out, reset_wrapper}, 2'b10);
        @(negedge sd_clock);
        check("ack_to_idle", {ack_out, reset_wrapper}, 2'b01);
    endtask

    task automatic run_cmd(input vec_t v);
        exp_q.push_back({v.exp_resp, 1'b0, 2'd0});
        strobe_in = 1'b1;
        resp_type = v.rt;
        @(negedge sd_clock);
        resp_type = 2'($urandom_range(0, 3));
        check("load_state", {load_send, enable_pts_wrapper, pad_state, pad_enable, reset_wrapper}, 5'b01110);
        @(negedge sd_clock);
        strobe_in = 1'b0;
        check("send_state", {load_send, enable_pts_wrapper, pad_state, pad_enable}, 4'b1111);
        repeat (v.tc_delay) @(negedge sd_clock);
        transmission_complete = 1'b1;
        @(negedge sd_clock);
        transmission_complete = 1'b0;
        if (v.rt == RESP_NONE) begin
            check("none_latency", {strobe_out, enable_stp_wrapper}, 2'b10);
        end else begin
            check("wait_resp_entry", {enable_stp_wrapper, pad_state, pad_enable}, 3'b100);
            repeat (v.rc_delay) @(negedge sd_clock);
            reception_complete = 1'b1;
            pad_response = v.pad;
            @(negedge sd_clock);
            reception_complete = 1'b0;
            pad_response = '0;
        end
        wait_strobe();
        last_resp = v.exp_resp;
        do_ack();
    endtask

    initial begin
        logic [159:0]      rnd;
        logic [RESP_W-1:0] r[4];
        logic [RESP_W-1:0] m48;
        logic [RESP_W-1:0] pat;
        int                n;

        m48 = '0;
        m48[47:0] = '1;
        pat = {8'hA5, {15{8'h3C}}, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            r[i] = rnd[RESP_W-1:0];
        end
        vecs[0] = '{RESP_LONG,  40, 5,  pat,  pat};
        vecs[1] = '{RESP_SHORT, 3,  0,  '1,   m48};
        vecs[2] = '{RESP_NONE,  0,  0,  r[0], '0};
        vecs[3] = '{2'd3,       2,  10, r[1], r[1]};
        vecs[4] = '{RESP_SHORT, 7,  20, r[2], r[2] & m48};
        vecs[5] = '{RESP_LONG,  1,  TIMEOUT_CYCLES - 1, r[3], r[3]};

        // Reset state
        repeat (3) @(negedge sd_clock);
        check("reset_ctl", ctl_vec(), 9'b000000100);
        check("reset_resp", {response, retry_count}, '0);
        reset = 1'b1;
        @(negedge sd_clock);
        check("idle_after_reset", ctl_vec(), 9'b000000100);

        for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

        // Abort in SEND, then in WAIT_RESP (idle_in beats reception_complete)
        strobe_in = 1'b1;
        resp_type = RESP_LONG;
        @(negedge sd_clock);
        strobe_in = 1'b0;
        @(negedge sd_clock);
        idle_in = 1'b1;
        @(negedge sd_clock);
        idle_in = 1'b0;
        check("abort_send", {reset_wrapper, load_send, enable_pts_wrapper}, 3'b100);
        check("abort_send_resp", response, last_resp);
        strobe_in = 1'b1;
        @(negedge sd_clock);
        strobe_in = 1'b0;
        @(negedge sd_clock);
        transmission_complete = 1'b1;
        @(negedge sd_clock);
        transmission_complete = 1'b0;
        repeat (10) @(negedge sd_clock);
        idle_in = 1'b1;
        reception_complete = 1'b1;
        pad_response = r[0];
        @(negedge sd_clock);
        idle_in = 1'b0;
        reception_complete = 1'b0;
        check("abort_wait", {reset_wrapper, enable_stp_wrapper, strobe_out}, 3'b100);
        repeat (3) @(negedge sd_clock);
        check("abort_wait_resp", response, last_resp);

        // Reception on the last WAIT_RESP cycle wins over the timeout
        run_cmd(vecs[5]);

        // Timeout with both retries used
        exp_q.push_back({{RESP_W{1'b0}}, 1'b1, 2'd2});
        strobe_in = 1'b1;
        resp_type = RESP_SHORT;
        @(negedge sd_clock);
        strobe_in = 1'b0;
        for (int a = 0; a < 3; a++) begin
            n = 0;
            while (!load_send && n < 10) begin
                @(negedge sd_clock);
                n++;
            end
            check("to_send", {{(EW-1){1'b0}}, load_send}, 1);
            transmission_complete = 1'b1;
            @(negedge sd_clock);
            transmission_complete = 1'b0;
            n = 0;
            while (enable_stp_wrapper && n < 200) begin
                n++;
                @(negedge sd_clock);
            end
            check("to_wait_len", EW'(n), EW'(TIMEOUT_CYCLES));
            if (a < 2) check("to_reload", {enable_pts_wrapper, load_send, retry_count}, {1'b1, 1'b0, RC_W'(a + 1)});
            else check("to_final", {strobe_out, command_timeout, retry_count}, {1'b1, 1'b1, 2'd2});
        end
        do_ack();
        check("retry_hold", {response, command_timeout, retry_count}, {{RESP_W{1'b0}}, 1'b1, 2'd2});

        // Reset asserted mid-transaction
        strobe_in = 1'b1;
        resp_type = RESP_LONG;
        @(negedge sd_clock);
        strobe_in = 1'b0;
        check("retry_clear", retry_count, 0);
        @(negedge sd_clock);
        transmission_complete = 1'b1;
        @(negedge sd_clock);
        transmission_complete = 1'b0;
        repeat (5) @(negedge sd_clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_ctl", ctl_vec(), 9'b000000100);
        check("midreset_resp", {response, command_timeout, retry_count}, '0);
        @(negedge sd_clock);
        reset = 1'b1;
        @(negedge sd_clock);

        run_cmd(vecs[0]);
        repeat (3) @(negedge sd_clock);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
